// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between a core request port and a
// single-beat DMEM, with sign/zero extension, beat timeout and fault codes.
// Ports:
//   clk, reset_n (async, active-low)
//   req_*  : request handshake, store flag, funct3 size code, address, data
//   dmem_* : beat request, aligned address, lane write enables, data, ack
//   rsp_*  : response handshake, load data, fault code
// Build option: LSU_MISALIGN_SPLIT_EN splits beat-crossing accesses into
// two beats; when undefined, addresses not aligned to the size fault 01.
module lsu_ctrl #(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_store,
   input  logic [2:0]      req_funct3,
   input  logic [AW-1:0]   req_addr,
   input  logic [DW-1:0]   req_wdata,
   output logic            dmem_req,
   output logic [AW-1:0]   dmem_addr,
   output logic [DW/8-1:0] dmem_we,
   output logic [DW-1:0]   dmem_wdata,
   input  logic            dmem_ack,
   input  logic [DW-1:0]   dmem_rdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [DW-1:0]   rsp_rdata,
   output logic [1:0]      rsp_fault
);

   localparam int NB = DW / 8;
   localparam int OW = $clog2(NB);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

   state_t          r_state, w_nstate;
   logic [AW-1:0]   r_base;
   logic [OW-1:0]   r_off;
   logic [2:0]      r_f3;
   logic            r_store;
   logic            r_cross;
   logic [DW-1:0]   r_wdata;
   logic [DW-1:0]   r_lo, w_lo;
   logic [DW-1:0]   r_rdata, w_rdata;
   logic [1:0]      r_fault, w_fault;
   logic [CW-1:0]   r_cnt, w_cnt;

   logic            w_acc, w_ill, w_mis, w_rcross;
   logic [OW-1:0]   w_roff;
   logic [3:0]      w_rszb, w_rszm, w_szb;
   logic [2*NB-1:0] w_smask, w_lmask;
   logic [2*DW-1:0] w_wide;
   logic [DW-1:0]   w_b0, w_b1;
   logic            w_beat, w_to;

   // Sign- or zero-extend the low 8*2^f3[1:0] bits of v to DW.
   function automatic logic [DW-1:0] ext(input logic [DW-1:0] v,
                                         input logic [2:0]    f3);
      logic [DW-1:0] m;
      int            nb;
      nb  = 8 << f3[1:0];
      m   = (nb >= DW) ? {DW{1'b1}} : ~({DW{1'b1}} << nb);
      ext = v & m;
      if (!f3[2] && nb < DW && v[nb-1])
         ext = ext | ~m;
   endfunction

   // Accept-time decode
   assign w_acc  = req_valid && (r_state == IDLE);
   assign w_roff = req_addr[OW-1:0];
   assign w_rszb = 4'd1 << req_funct3[1:0];
   assign w_rszm = w_rszb - 4'd1;
   assign w_ill  = (req_funct3 == 3'b111) ||
                   ((DW == 32) && ((req_funct3 == 3'b011) ||
                                   (req_funct3 == 3'b110)));
`ifdef LSU_MISALIGN_SPLIT_EN
   assign w_mis    = 1'b0;
   assign w_rcross = (int'(w_roff) + int'(w_rszb)) > NB;
`else
   assign w_mis    = ({{(4-OW){1'b0}}, w_roff} & w_rszm) != 4'd0;
   assign w_rcross = 1'b0;
`endif

   // Lane mask and data spread over two beats; the upper half is the
   // spill-over into the second beat.
   assign w_szb   = 4'd1 << r_f3[1:0];
   assign w_smask = ({{(2*NB-1){1'b0}}, 1'b1} << w_szb)
                    - {{(2*NB-1){1'b0}}, 1'b1};
   assign w_lmask = w_smask << r_off;
   assign w_wide  = {{DW{1'b0}}, r_wdata} << {r_off, 3'b000};

   // Beat0 supplies the low bytes of the result, beat1 the rest.
   assign w_b0 = dmem_rdata >> {r_off, 3'b000};
   assign w_b1 = r_lo | (dmem_rdata << (DW - int'({r_off, 3'b000})));

   assign w_beat = (r_state == BEAT0) || (r_state == BEAT1);
   assign w_to   = (r_cnt == CW'(TIMEOUT - 1));

   assign req_ready  = (r_state == IDLE);
   assign rsp_valid  = (r_state == RESP);
   assign rsp_rdata  = r_rdata;
   assign rsp_fault  = r_fault;
   assign dmem_req   = w_beat;
   assign dmem_addr  = !w_beat ? '0 :
                       (r_state == BEAT1) ? r_base + AW'(NB) : r_base;
   assign dmem_we    = !(w_beat && r_store) ? '0 :
                       (r_state == BEAT1) ? w_lmask[2*NB-1:NB]
                                          : w_lmask[NB-1:0];
   assign dmem_wdata = !w_beat ? '0 :
                       (r_state == BEAT1) ? w_wide[2*DW-1:DW]
                                          : w_wide[DW-1:0];

   always_comb begin
      w_nstate = r_state;
      w_cnt    = r_cnt;
      w_lo     = r_lo;
      w_rdata  = r_rdata;
      w_fault  = r_fault;
      unique case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_rdata = '0;
               w_cnt   = '0;
               if (w_ill) begin
                  w_fault  = 2'b11;
                  w_nstate = RESP;
               end else if (w_mis) begin
                  w_fault  = 2'b01;
                  w_nstate = RESP;
               end else begin
                  w_fault  = 2'b00;
                  w_nstate = BEAT0;
               end
            end
         end
         BEAT0: begin
            if (dmem_ack) begin
               w_cnt = '0;
               if (r_cross) begin
                  w_lo     = w_b0;
                  w_nstate = BEAT1;
               end else begin
                  w_rdata  = r_store ? '0 : ext(w_b0, r_f3);
                  w_nstate = RESP;
               end
            end else if (w_to) begin
               w_fault  = 2'b10;
               w_rdata  = '0;
               w_nstate = RESP;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         BEAT1: begin
            if (dmem_ack) begin
               w_rdata  = r_store ? '0 : ext(w_b1, r_f3);
               w_nstate = RESP;
            end else if (w_to) begin
               w_fault  = 2'b10;
               w_rdata  = '0;
               w_nstate = RESP;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready)
               w_nstate = IDLE;
         end
         default: w_nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_base  <= '0;
         r_off   <= '0;
         r_f3    <= '0;
         r_store <= 1'b0;
         r_cross <= 1'b0;
         r_wdata <= '0;
         r_lo    <= '0;
         r_rdata <= '0;
         r_fault <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nstate;
         r_lo    <= w_lo;
         r_rdata <= w_rdata;
         r_fault <= w_fault;
         r_cnt   <= w_cnt;
         if (w_acc) begin
            r_base  <= {req_addr[AW-1:OW], {OW{1'b0}}};
            r_off   <= w_roff;
            r_f3    <= req_funct3;
            r_store <= req_store;
            r_cross <= w_rcross;
            r_wdata <= req_wdata;
         end
      end
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data width; legal values 32 or 64; NB = DW/8 byte lanes.
REQ-002 SHALL have parameter AW, default 32, meaning address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning maximum cycles dmem_req may be held without dmem_ack.
REQ-004 SHALL have port clk  in  1  meaning the single clock.
REQ-005 SHALL have port reset_n  in  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have ports req_valid in 1 / req_ready out 1, meaning the request handshake.
REQ-007 SHALL have port req_store  in  1  meaning 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  in  3  meaning RV size/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-009 SHALL have ports req_addr in AW and req_wdata in DW, meaning the byte address and the store data (LSB-justified).
REQ-010 SHALL have ports dmem_req out 1, dmem_addr out AW (NB-aligned), dmem_we out NB (per-lane write enable), dmem_wdata out DW, meaning the DMEM request side.
REQ-011 SHALL have ports dmem_ack in 1 and dmem_rdata in DW, meaning the DMEM beat completion and read data.
REQ-012 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out DW, rsp_fault out 2, meaning the response; rsp_fault codes: 00 ok, 01 misaligned, 10 timeout, 11 illegal size.

Function
REQ-013 SHALL implement FSM states IDLE, BEAT0, BEAT1, RESP; req_ready SHALL be 1 only in IDLE.
REQ-014 SHALL register the request on req_valid&&req_ready and go to BEAT0, or go to RESP directly when a fault is detected at accept.
REQ-015 SHALL fault 11 and issue no DMEM beat for funct3 111, or for 011/110 when DW=32.
REQ-016 SHALL compute size S = 1/2/4/8 bytes and offset O = addr mod NB; an access SHALL cross a beat when O+S > NB.
REQ-017 In BEAT0 SHALL drive dmem_req=1, dmem_addr = addr with low log2(NB) bits cleared, dmem_we = store ? ((2^S-1)<<O) truncated to NB lanes : 0, dmem_wdata = wdata<<8*O; outputs SHALL hold until dmem_ack.
REQ-018 On dmem_ack in BEAT0 SHALL capture read lanes and go to BEAT1 if crossing, else RESP.
REQ-019 In BEAT1 SHALL drive dmem_addr = beat0 address + NB, dmem_we = remaining (O+S-NB) low lanes for stores, dmem_wdata = wdata>>8*(NB-O); the load result SHALL be merged as {beat1 low bytes, beat0 high bytes}.
REQ-020 Load result SHALL be sign-extended for B/H/W and zero-extended for BU/HU/WU to DW; stores SHALL return rsp_rdata=0.
REQ-021 SHALL count consecutive cycles with dmem_req=1 and dmem_ack=0 (counter cleared at each beat start); when the count reaches TIMEOUT SHALL drop dmem_req, set fault 10, and go to RESP; an already-written BEAT0 SHALL NOT be rolled back.
REQ-022 In RESP rsp_valid=1, and rsp_rdata/rsp_fault SHALL be stable until rsp_ready; then return to IDLE; a new request SHALL NOT be accepted in the same cycle (one bubble).
REQ-023 Best-case latency: accept at cycle N, dmem_req at N+1, ack at N+1, rsp_valid at N+2.
REQ-024 dmem_ack outside BEAT0/BEAT1 SHALL be ignored.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE; dmem_req, dmem_we, dmem_wdata, dmem_addr, rsp_valid, rsp_rdata, rsp_fault = 0; req_ready SHALL be 1 after release.
REQ-026 Reset mid-transaction SHALL drop dmem_req immediately and produce no response for the aborted request.

Configuration
REQ-027 Macro LSU_MISALIGN_SPLIT_EN defined: beat-crossing accesses SHALL be split per REQ-019.
REQ-028 Macro LSU_MISALIGN_SPLIT_EN undefined: any access with addr not a multiple of S SHALL fault 01 at accept with no DMEM beat, and BEAT1 SHALL be unreachable.

Verification
REQ-029 SB addr 0x1003 wdata 0xA5, ack immediate -> dmem_addr 0x1000, dmem_we 1000b, dmem_wdata 0xA5000000, rsp_fault 00.
REQ-030 LH addr 0x2002, dmem_rdata 0x8001_1234 -> rsp_rdata 0xFFFF8001; LHU with the same data -> 0x00008001.
REQ-031 LW addr 0x3002 with the macro, beats return 0xDDCCBBAA @0x3000 and 0x44332211 @0x3004 -> rsp_rdata 0x2211DDCC; without the macro -> fault 01, dmem_req never asserted.
REQ-032 TIMEOUT=4, dmem_ack held 0 -> dmem_req high exactly 4 cycles, then rsp_valid with rsp_fault 10.
REQ-033 reset_n pulsed low during BEAT0 -> dmem_req 0 in the same cycle, no rsp_valid, req_ready 1 after release.
REQ-034 rsp_ready held 0 for 3 cycles in RESP -> rsp_valid, rsp_rdata, rsp_fault unchanged and req_ready 0 throughout.
